ppu_render_scheduler: RTL and testbench

Frame-level sequencer that drives the PPU VRAM tile-load FSM across the visible screen. It walks rows 0–239 and, within each row, 8-pixel tile groups offset by fine-X scroll, issuing one start per group and waiting for its completion. Between rows it optionally handshakes with the sprite evaluator. After row 239 it runs a timed vertical-blank period with flag and NMI generation. It sits between the PPU register file and the tile-load FSM and owns `curr_row`/`curr_col`.

---
 rtl/ppu_pkg.sv | 15 +
 rtl/ppu_vblank_timer.sv | 35 +++
 rtl/ppu_render_scheduler.sv | 109 ++++++++++
 tb/tb_ppu_render_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared scheduler state encoding and frame geometry for the PPU render path.
package ppu_pkg;
    typedef enum logic [2:0] {
        S_ROW_BEGIN,
        S_EVAL_WAIT,
        S_ISSUE,
        S_ACK,
        S_DONE_WAIT,
        S_NEXT,
        S_VBLANK
    } sched_state_t;
    localparam int PPU_VISIBLE_ROWS  = 240;
    localparam int PPU_TILE_W        = 8;
    localparam int PPU_VBLANK_CYCLES = 6820;
endpackage

// File: rtl/ppu_vblank_timer.sv
// ppu_vblank_timer: vertical-blank counter, status flag and one-shot NMI / frame_done pulses.
module ppu_vblank_timer
    import ppu_pkg::*;
#(
    parameter int VBLANK_CYCLES = PPU_VBLANK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic nmi_en,
    input  logic status_read,
    output logic expire,
    output logic vblank_flag,
    output logic nmi,
    output logic frame_done
);
    localparam int CW = $clog2(VBLANK_CYCLES);
    logic [CW-1:0] cnt;
    assign expire = active && cnt == CW'(VBLANK_CYCLES - 1);
    // NMI is only sampled on vblank entry, so a late enable does not fire one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            vblank_flag <= 1'b0;
            nmi         <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            cnt         <= start ? '0 : (active ? cnt + 1'b1 : cnt);
            vblank_flag <= start | (vblank_flag & ~status_read & ~expire);
            nmi         <= start & nmi_en;
            frame_done  <= expire;
        end
    end
endmodule

// File: rtl/ppu_render_scheduler.sv
// ppu_render_scheduler: walks visible rows and tile groups, issuing tile loads, then times vblank.
// Define PPU_SCHED_SPRITE_EVAL_EN to add the per-row sprite-evaluator handshake.
module ppu_render_scheduler
    import ppu_pkg::*;
#(
    parameter int VBLANK_CYCLES = PPU_VBLANK_CYCLES,
    parameter int LAST_ROW      = PPU_VISIBLE_ROWS - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ppu_ctrl1,
    input  logic [7:0] ppu_ctrl2,
    input  logic [2:0] fine_x,
    input  logic       status_read,
    input  logic       load_busy,
    output logic       load_start,
    output logic [8:0] curr_row,
    output logic [8:0] curr_col,
    output logic       eval_req,
    input  logic       eval_done,
    output logic       vblank_flag,
    output logic       nmi,
    output logic       frame_done
);
    sched_state_t state;
    logic [5:0] tc, last_tc;
    logic vb_start, vb_expire, unused_bits;
    assign vb_start = state == S_NEXT && tc == last_tc && curr_row == 9'(LAST_ROW);
`ifdef PPU_SCHED_SPRITE_EVAL_EN
    assign unused_bits = ^{ppu_ctrl1[6:0], ppu_ctrl2[7:5], ppu_ctrl2[2:0]};
`else
    assign unused_bits = ^{ppu_ctrl1[6:0], ppu_ctrl2[7:5], ppu_ctrl2[2:0], eval_done};
    assign eval_req    = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_ROW_BEGIN;
            curr_row   <= '0;
            curr_col   <= '0;
            tc         <= '0;
            last_tc    <= '0;
            load_start <= 1'b0;
`ifdef PPU_SCHED_SPRITE_EVAL_EN
            eval_req   <= 1'b0;
`endif
        end else begin
            load_start <= 1'b0;
`ifdef PPU_SCHED_SPRITE_EVAL_EN
            eval_req   <= 1'b0;
`endif
            case (state)
                S_ROW_BEGIN: begin
                    // A nonzero fine scroll exposes one extra partial group on the left.
                    curr_col <= 9'd0 - 9'(fine_x);
                    tc       <= '0;
                    last_tc  <= (fine_x == 3'd0) ? 6'd31 : 6'd32;
`ifdef PPU_SCHED_SPRITE_EVAL_EN
                    eval_req <= 1'b1;
                    state    <= S_EVAL_WAIT;
`else
                    state    <= S_ISSUE;
`endif
                end
`ifdef PPU_SCHED_SPRITE_EVAL_EN
                S_EVAL_WAIT: if (eval_done) state <= S_ISSUE;
`endif
                S_ISSUE: begin
                    if (ppu_ctrl2[4:3] == 2'b00) state <= S_NEXT;
                    else if (!load_busy) begin
                        load_start <= 1'b1;
                        state      <= S_ACK;
                    end
                end
                S_ACK: state <= S_DONE_WAIT;
                S_DONE_WAIT: if (!load_busy) state <= S_NEXT;
                S_NEXT: begin
                    if (tc != last_tc) begin
                        tc       <= tc + 1'b1;
                        curr_col <= curr_col + 9'(PPU_TILE_W);
                        state    <= S_ISSUE;
                    end else if (vb_start) state <= S_VBLANK;
                    else begin
                        curr_row <= curr_row + 1'b1;
                        state    <= S_ROW_BEGIN;
                    end
                end
                S_VBLANK: begin
                    if (vb_expire) begin
                        curr_row <= '0;
                        state    <= S_ROW_BEGIN;
                    end
                end
                default: state <= S_ROW_BEGIN;
            endcase
        end
    end
    ppu_vblank_timer #(.VBLANK_CYCLES(VBLANK_CYCLES)) u_vblank (
        .clk         (clk),
        .rst         (rst),
        .start       (vb_start),
        .active      (state == S_VBLANK),
        .nmi_en      (ppu_ctrl1[7]),
        .status_read (status_read),
        .expire      (vb_expire),
        .vblank_flag (vblank_flag),
        .nmi         (nmi),
        .frame_done  (frame_done)
    );
endmodule

// File: tb/tb_ppu_render_scheduler.sv
// tb_ppu_render_scheduler: directed table and sequence checks on a shortened frame (4 rows, 200-cycle vblank).
module tb_ppu_render_scheduler;
    localparam int VB   = 200;
    localparam int LR   = 3;
    localparam int ROWS = LR + 1;
`ifdef PPU_SCHED_SPRITE_EVAL_EN
    localparam int EV = 1;
`else
    localparam int EV = 0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] ppu_ctrl1 = 8'h00, ppu_ctrl2 = 8'h18;
    logic [2:0] fine_x = 3'd0;
    logic status_read = 1'b0, eval_mode = 1'b0;
    logic load_busy, eval_done, load_start, eval_req, vblank_flag, nmi, frame_done;
    logic [8:0] curr_row, curr_col;
    logic [3:0] busy_cnt, ev_cnt;

    ppu_render_scheduler #(.VBLANK_CYCLES(VB), .LAST_ROW(LR)) dut (
        .clk(clk), .rst(rst), .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2),
        .fine_x(fine_x), .status_read(status_read), .load_busy(load_busy),
        .load_start(load_start), .curr_row(curr_row), .curr_col(curr_col),
        .eval_req(eval_req), .eval_done(eval_done), .vblank_flag(vblank_flag),
        .nmi(nmi), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Tile-load model: busy for 6 cycles starting the cycle after load_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_cnt <= '0;
        else if (load_start) busy_cnt <= 4'd6;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1'b1;
    end
    assign load_busy = busy_cnt != 0;

    // Evaluator model: either always done, or a done pulse 10 cycles after eval_req.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ev_cnt <= '0;
        else if (eval_req) ev_cnt <= 4'd10;
        else if (ev_cnt != 0) ev_cnt <= ev_cnt - 1'b1;
    end
    assign eval_done = eval_mode ? (ev_cnt == 4'd1) : 1'b1;

    int n_start = 0, n_nmi = 0, n_nmi_bad = 0, n_fd = 0, n_eval = 0, n_hi = 0, n_viol = 0;
    logic [8:0] col_q[$];
    logic waiting = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (load_start) begin
                n_start++;
                col_q.push_back(curr_col);
                if (waiting) n_viol++;
            end
            if (nmi) begin
                n_nmi++;
                if (!vblank_flag) n_nmi_bad++;
            end
            if (frame_done) n_fd++;
            if (eval_req) begin
                n_eval++;
                waiting = eval_mode;
            end
            if (eval_done && eval_mode) waiting = 1'b0;
            if (vblank_flag) n_hi++;
        end
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [2:0] fx;
        logic [7:0] c2;
        int starts;
        int first;
        int last;
        int cycles;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int n, b_start, b_q, b_nmi, b_fd, b_hi, b_eval, b_viol;
        tbl[0] = '{3'd0, 8'h18, 32, 0,   248, 321};
        tbl[1] = '{3'd5, 8'h18, 33, 507, 251, 331};
        tbl[2] = '{3'd3, 8'h08, 33, 509, 253, 331};
        tbl[3] = '{3'd7, 8'h10, 33, 505, 249, 331};
        tbl[4] = '{3'd0, 8'h00, 0,  0,   0,   65};
        tbl[5] = '{3'd6, 8'hE7, 0,  0,   0,   67};

        // Asynchronous reset while running: outputs drop without a clock edge.
        repeat (20) step();
        #2 rst = 1'b0;
        #1;
        chk("rst_load_start", load_start, 0);
        chk("rst_row", curr_row, 0);
        chk("rst_col", curr_col, 0);
        chk("rst_vblank", vblank_flag, 0);
        chk("rst_nmi", nmi, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_eval_req", eval_req, 0);
        step();
        rst = 1'b1;

        // Row 0 walk for each scroll / render-enable combination.
        for (int i = 0; i < 6; i++) begin
            fine_x = tbl[i].fx;
            ppu_ctrl2 = tbl[i].c2;
            do_reset();
            b_start = n_start;
            b_q = col_q.size();
            n = 0;
            while (curr_row != 9'd1 && n < 2000) begin
                step();
                n++;
            end
            chk("row_cycles", n, tbl[i].cycles + EV);
            chk("row_starts", n_start - b_start, tbl[i].starts);
            if (tbl[i].starts > 0 && col_q.size() > b_q) begin
                chk("first_col", col_q[b_q], tbl[i].first);
                chk("last_col", col_q[col_q.size() - 1], tbl[i].last);
            end
        end

        // Reset asserted while load_start is high in row 1.
        fine_x = 3'd0;
        ppu_ctrl2 = 8'h18;
        do_reset();
        n = 0;
        while (!(curr_row == 9'd1 && load_start && curr_col == 9'd16) && n < 3000) begin
            step();
            n++;
        end
        chk("midtile_reached", n < 3000, 1);
        #2 rst = 1'b0;
        #1;
        chk("midtile_load_start", load_start, 0);
        chk("midtile_row", curr_row, 0);
        chk("midtile_col", curr_col, 0);
        step();
        rst = 1'b1;

        // Full rendered frame with NMI enabled.
        ppu_ctrl1 = 8'h80;
        do_reset();
        b_start = n_start; b_nmi = n_nmi; b_fd = n_fd; b_hi = n_hi; b_eval = n_eval;
        n = 0;
        while (n_fd == b_fd && n < 5000) begin
            step();
            n++;
        end
        chk("frame_cycles", n, ROWS * 321 + VB + ROWS * EV);
        chk("frame_starts", n_start - b_start, ROWS * 32);
        chk("frame_nmi", n_nmi - b_nmi, 1);
        chk("nmi_with_flag", n_nmi_bad, 0);
        chk("frame_flag_hi", n_hi - b_hi, VB);
        chk("frame_row_wrap", curr_row, 0);
        chk("frame_eval_req", n_eval - b_eval, ROWS * EV);

        // Render disabled, NMI disabled: no loads, short frame.
        ppu_ctrl1 = 8'h00;
        ppu_ctrl2 = 8'h00;
        do_reset();
        b_start = n_start; b_nmi = n_nmi; b_fd = n_fd;
        n = 0;
        while (n_fd == b_fd && n < 5000) begin
            step();
            n++;
        end
        chk("off_cycles", n, ROWS * 65 + VB + ROWS * EV);
        chk("off_starts", n_start - b_start, 0);
        chk("off_nmi", n_nmi - b_nmi, 0);

        // status_read 100 cycles into vblank clears the flag; one NMI only.
        ppu_ctrl1 = 8'h80;
        do_reset();
        b_nmi = n_nmi; b_fd = n_fd; b_hi = n_hi;
        n = 0;
        while (!vblank_flag && n < 2000) begin
            step();
            n++;
        end
        chk("sr_flag_set", vblank_flag, 1);
        repeat (100) step();
        status_read = 1'b1;
        step();
        status_read = 1'b0;
        chk("sr_flag_cleared", vblank_flag, 0);
        n = 0;
        while (n_fd == b_fd && n < 2000) begin
            step();
            n++;
        end
        chk("sr_nmi", n_nmi - b_nmi, 1);
        chk("sr_flag_hi", n_hi - b_hi, 101);

        // NMI enable rising mid-vblank must not produce an NMI.
        ppu_ctrl1 = 8'h00;
        b_nmi = n_nmi; b_fd = n_fd;
        n = 0;
        while (!vblank_flag && n < 2000) begin
            step();
            n++;
        end
        repeat (10) step();
        ppu_ctrl1 = 8'h80;
        n = 0;
        while (n_fd == b_fd && n < 2000) begin
            step();
            n++;
        end
        chk("late_enable_nmi", n_nmi - b_nmi, 0);

        // status_read held through vblank entry: set wins for exactly one cycle.
        status_read = 1'b1;
        b_hi = n_hi; b_fd = n_fd;
        n = 0;
        while (n_fd == b_fd && n < 2000) begin
            step();
            n++;
        end
        status_read = 1'b0;
        chk("set_wins_flag_hi", n_hi - b_hi, 1);

        // Reset during vblank clears the flag immediately.
        n = 0;
        while (!vblank_flag && n < 2000) begin
            step();
            n++;
        end
        #2 rst = 1'b0;
        #1;
        chk("vb_rst_flag", vblank_flag, 0);
        chk("vb_rst_row", curr_row, 0);
        step();
        rst = 1'b1;

`ifdef PPU_SCHED_SPRITE_EVAL_EN
        // Delayed evaluator: no loads before eval_done, one request per row.
        ppu_ctrl2 = 8'h18;
        eval_mode = 1'b1;
        do_reset();
        b_eval = n_eval; b_viol = n_viol; b_start = n_start;
        n = 0;
        while (curr_row != 9'd2 && n < 3000) begin
            step();
            n++;
        end
        chk("eval_req_rows", n_eval - b_eval, 2);
        chk("eval_early_start", n_viol - b_viol, 0);
        chk("eval_starts", n_start - b_start, 64);
        eval_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
